// File: rtl/movavg_pkg.sv
// Shared definitions for the parametrised moving-average block.
//   ow_f      : output/accumulator width for a W-bit sample over a 2**depth_log2 window
//   MODE_SUM  : dout carries the full window sum
//   MODE_MEAN : dout carries the window sum shifted right by depth_log2 (floor)
package movavg_pkg;

  localparam logic MODE_SUM  = 1'b0;
  localparam logic MODE_MEAN = 1'b1;

  // The sum of 2**d values below 2**w always fits in w+d bits, so no
  // log2 helper is needed to size the accumulator.
  function automatic int ow_f(input int w, input int depth_log2);
    return w + depth_log2;
  endfunction

endpackage

// File: rtl/movavg_tapline.sv
// Circular buffer of N = 2**DEPTH_LOG2 sample taps with a write pointer.
//   clk    : rising-edge clock
//   reset  : synchronous active-low reset; zeroes taps and pointer
//   zero   : synchronous flush; zeroes taps and pointer (reset has priority)
//   push   : write din into the tap at the pointer and advance the pointer
//   din    : sample to store
//   oldest : tap at the pointer, i.e. the sample about to be overwritten
//   wp     : current write pointer (exposed for observation)
module movavg_tapline #(
  parameter int W          = 64,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  zero,
  input  logic                  push,
  input  logic [W-1:0]          din,
  output logic [W-1:0]          oldest,
  output logic [DEPTH_LOG2-1:0] wp
);

  localparam int N = 1 << DEPTH_LOG2;

  logic [W-1:0] taps [N];

  // Combinational read of the tap about to be replaced; the caller uses
  // this value in the same cycle the push overwrites it (read-before-write).
  assign oldest = taps[wp];

  always_ff @(posedge clk) begin
    if (!reset || zero) begin
      for (int i = 0; i < N; i++) taps[i] <= '0;
      wp <= '0;
    end else if (push) begin
      taps[wp] <= din;
      // Power-of-two depth: the natural wrap of wp is modulo N.
      wp <= wp + DEPTH_LOG2'(1);
    end
  end

endmodule

// File: rtl/movavg_param.sv
// Moving sum / mean over a window of N = 2**DEPTH_LOG2 unsigned samples,
// one sample per cycle, using a running sum (add newest, subtract oldest).
//   clk       : rising-edge clock
//   reset     : synchronous active-low reset
//   in_valid  : din carries a sample this cycle
//   din       : W-bit unsigned sample
//   mode      : MODE_SUM -> window sum, MODE_MEAN -> sum >> DEPTH_LOG2
//   clear     : synchronous active-high flush of the window (drops a
//               coincident sample)
//   out_valid : dout updated this cycle
//   dout      : OW-bit result, registered
//   full      : window holds N samples since the last reset/clear
//
// Handshake: a sample is accepted on any rising edge with in_valid=1,
// clear=0, reset=1; there is no back-pressure. The result including that
// sample is presented one cycle later with out_valid=1 for exactly that
// cycle; dout holds between results.
module movavg_param
  import movavg_pkg::*;
#(
  parameter  int W          = 64,
  parameter  int DEPTH_LOG2 = 2,
  localparam int OW         = ow_f(W, DEPTH_LOG2)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [W-1:0]  din,
  input  logic          mode,
  input  logic          clear,
  output logic          out_valid,
  output logic [OW-1:0] dout,
  output logic          full
);

  localparam logic [DEPTH_LOG2:0] N_CNT = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);

  logic                  accept;
  logic [W-1:0]          oldest;
  logic [DEPTH_LOG2-1:0] wp;
  logic [OW-1:0]         sum;
  logic [OW-1:0]         sum_next;
  logic [OW-1:0]         mean_next;
  logic [DEPTH_LOG2:0]   fill_cnt;
  logic [DEPTH_LOG2:0]   fill_cnt_next;

  assign accept = in_valid && !clear;

  movavg_tapline #(
    .W          (W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_tapline (
    .clk    (clk),
    .reset  (reset),
    .zero   (clear),
    .push   (accept),
    .din    (din),
    .oldest (oldest),
    .wp     (wp)
  );

  // The sum never exceeds N*(2**W-1) < 2**OW, and the tap being removed is
  // always already part of sum, so the subtraction cannot underflow.
  assign sum_next  = sum + {{DEPTH_LOG2{1'b0}}, din} - {{DEPTH_LOG2{1'b0}}, oldest};
  assign mean_next = sum_next >> DEPTH_LOG2;

  assign fill_cnt_next = (fill_cnt == N_CNT) ? fill_cnt
                                             : fill_cnt + (DEPTH_LOG2 + 1)'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sum       <= '0;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      full      <= 1'b0;
    end else if (clear) begin
      // dout deliberately holds its last value across a clear.
      sum       <= '0;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
      full      <= 1'b0;
    end else if (in_valid) begin
      sum       <= sum_next;
      fill_cnt  <= fill_cnt_next;
      out_valid <= 1'b1;
      dout      <= (mode == MODE_MEAN) ? mean_next : sum_next;
      full      <= (fill_cnt_next == N_CNT);
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_movavg_param.sv
module tb_movavg_param;

  localparam int W          = 8;
  localparam int DEPTH_LOG2 = 2;
  localparam int OW         = W + DEPTH_LOG2;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [W-1:0]  din;
  logic          mode;
  logic          clear;
  logic          out_valid;
  logic [OW-1:0] dout;
  logic          full;

  int n_checks;
  int n_fail;

  // Scoreboard: expected dout and full per accepted sample.
  logic [OW-1:0] exp_q[$];
  logic          exp_full_q[$];
  logic [OW-1:0] held_dout;

  movavg_param #(
    .W          (W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .din       (din),
    .mode      (mode),
    .clear     (clear),
    .out_valid (out_valid),
    .dout      (dout),
    .full      (full)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; outputs are sampled 1 time unit
  // after the rising edge that registered them.
  task automatic push(input logic [W-1:0] d, input logic m,
                      input logic [OW-1:0] exp_dout, input logic exp_full);
    logic [OW-1:0] e;
    logic          ef;
    exp_q.push_back(exp_dout);
    exp_full_q.push_back(exp_full);
    @(negedge clk);
    in_valid = 1'b1;
    din      = d;
    mode     = m;
    clear    = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    ef = exp_full_q.pop_front();
    held_dout = e;
    check($sformatf("out_valid din=%0d", d), 32'(out_valid), 32'd1);
    check($sformatf("dout din=%0d", d), 32'(dout), 32'(e));
    check($sformatf("full din=%0d", d), 32'(full), 32'(ef));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      clear    = 1'b0;
      din      = W'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      check("idle out_valid", 32'(out_valid), 32'd0);
      check("idle dout hold", 32'(dout), 32'(held_dout));
    end
  endtask

  // Clear with an optional coincident sample that must be dropped.
  task automatic do_clear(input logic v, input logic [W-1:0] d);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = v;
    din      = d;
    @(posedge clk);
    #1;
    check("clear out_valid", 32'(out_valid), 32'd0);
    check("clear full", 32'(full), 32'd0);
    check("clear dout hold", 32'(dout), 32'(held_dout));
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
  endtask

  // One-cycle reset with in_valid and clear asserted to show reset wins.
  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b1;
    clear    = 1'b1;
    din      = 8'd77;
    @(posedge clk);
    #1;
    held_dout = '0;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset dout", 32'(dout), 32'd0);
    check("reset full", 32'(full), 32'd0);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    held_dout = '0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    din       = '0;
    mode      = 1'b0;
    clear     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post-reset out_valid", 32'(out_valid), 32'd0);
    check("post-reset dout", 32'(dout), 32'd0);
    check("post-reset full", 32'(full), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Sum mode, warm-up and first wrap.
    push(8'd10, 1'b0, 10'd10,  1'b0);
    push(8'd20, 1'b0, 10'd30,  1'b0);
    push(8'd30, 1'b0, 10'd60,  1'b0);
    push(8'd40, 1'b0, 10'd100, 1'b1);
    push(8'd50, 1'b0, 10'd140, 1'b1);

    // Mean mode on the same stream from an empty window.
    do_clear(1'b0, 8'd0);
    push(8'd10, 1'b1, 10'd2,  1'b0);
    push(8'd20, 1'b1, 10'd7,  1'b0);
    push(8'd30, 1'b1, 10'd15, 1'b0);
    push(8'd40, 1'b1, 10'd25, 1'b1);
    push(8'd50, 1'b1, 10'd35, 1'b1);

    // Maximum samples: no wrap at 2**W.
    do_clear(1'b0, 8'd0);
    push(8'd255, 1'b0, 10'd255,  1'b0);
    push(8'd255, 1'b0, 10'd510,  1'b0);
    push(8'd255, 1'b0, 10'd765,  1'b0);
    push(8'd255, 1'b0, 10'd1020, 1'b1);
    push(8'd255, 1'b0, 10'd1020, 1'b1);
    push(8'd255, 1'b0, 10'd1020, 1'b1);
    push(8'd255, 1'b0, 10'd1020, 1'b1);
    push(8'd255, 1'b1, 10'd255,  1'b1);

    // Gap in the stream: pipeline holds.
    do_clear(1'b0, 8'd0);
    push(8'd10, 1'b0, 10'd10, 1'b0);
    push(8'd20, 1'b0, 10'd30, 1'b0);
    idle(3);
    push(8'd30, 1'b0, 10'd60, 1'b0);

    // Clear with a coincident sample that must be dropped.
    do_clear(1'b0, 8'd0);
    push(8'd40, 1'b0, 10'd40,  1'b0);
    push(8'd40, 1'b0, 10'd80,  1'b0);
    push(8'd40, 1'b0, 10'd120, 1'b0);
    push(8'd40, 1'b0, 10'd160, 1'b1);
    do_clear(1'b1, 8'd99);
    push(8'd5, 1'b0, 10'd5,  1'b0);
    push(8'd7, 1'b0, 10'd12, 1'b0);

    // Mid-stream reset, then a fresh window and a mode switch.
    do_reset();
    push(8'd1, 1'b0, 10'd1,  1'b0);
    push(8'd2, 1'b0, 10'd3,  1'b0);
    push(8'd3, 1'b0, 10'd6,  1'b0);
    push(8'd4, 1'b0, 10'd10, 1'b1);
    push(8'd5, 1'b1, 10'd3,  1'b1);  // window 2+3+4+5=14, mean 3
    push(8'd6, 1'b0, 10'd18, 1'b1);  // window 3+4+5+6, sum intact
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/movavg_param.md
Name: movavg_param

Overview:
- Parametrised successor to the fixed 4-tap, 64-bit moving-sum block.
- Width and window depth are configurable; the block adds a valid handshake, a sum/mean mode, a synchronous clear, and a registered output.
- Uses a running-sum implementation (add newest sample, subtract oldest) over a circular tap buffer, so cost does not grow with depth in the adder path.
- Sits in the datapath between a sample producer and a downstream consumer; one sample per cycle at full rate (DII 1).

Parameters:
- W, 64, input sample width in bits (unsigned).
- DEPTH_LOG2, 2, log2 of the window length; window N = 2**DEPTH_LOG2 (legal range 1..8).
- OW, W+DEPTH_LOG2, output width; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the next clk edge).
- in_valid  in  1  din carries a sample this cycle.
- din  in  W  sample, unsigned.
- mode  in  1  0 = output full window sum; 1 = output mean (sum >> DEPTH_LOG2, floor).
- clear  in  1  synchronous flush of the window; active-high.
- out_valid  out  1  dout updated this cycle.
- dout  out  OW  window sum or mean, zero-extended to OW in mean mode.
- full  out  1  window holds N samples since the last reset or clear.

Behaviour:
- Reset (reset==0 at a clk edge):
  - All N taps, the running sum, the write pointer and the fill count go to 0.
  - out_valid=0, dout=0, full=0.
  - Reset overrides clear and in_valid.
- Accepted sample (in_valid=1, clear=0, reset=1):
  - Next sum = sum + din - tap[wp].
  - tap[wp] <= din; wp <= wp+1, wrapping modulo N.
  - Fill count saturates at N.
- Latency: dout and out_valid are registered. The result including sample k appears the cycle after k is accepted, with out_valid=1 for exactly that cycle.
- in_valid=0: taps, sum and pointer hold; out_valid=0; dout holds its last value.
- Warm-up: taps start at 0, so with fewer than N samples dout is the sum of the samples seen so far (mean mode still divides by N). full rises together with the out_valid of the Nth sample.
- Arithmetic:
  - The sum is kept in OW bits and never overflows (N*(2**W-1) < 2**OW).
  - No wrap modulo 2**W, unlike the previous generation.
  - mode is sampled with the accepted sample and affects only the dout formatting of that result. Switching mode mid-stream does not disturb the sum.
- clear=1 (reset=1):
  - Taps, sum, pointer and fill count go to 0; out_valid=0; full=0; dout holds.
  - A simultaneous in_valid sample is dropped (clear wins).
- Reset or clear mid-stream: the next accepted sample is treated as the first of a fresh window; no stale taps contribute.
- Pointer wrap: after sample N-1 the pointer returns to 0. Sample N then replaces sample 0. The subtracted value is the tap read before the write in the same cycle (read-before-write).

Decomposition:
- Package movavg_pkg: function clog2-free width helper ow_f(W, DEPTH_LOG2); localparam MODE_SUM=1'b0, MODE_MEAN=1'b1.
- Sub-module movavg_tapline:
  - N x W register circular buffer with write pointer.
  - Advances on a push; exposes the oldest-tap read value and a synchronous zeroing input.
  - The top level holds the running-sum accumulator, fill counter and output register.

Test Plan:
- W=8, DEPTH_LOG2=2, mode=0; push 10,20,30,40,50 back-to-back -> dout 10,30,60,100,140 on successive cycles, each with out_valid=1; full=1 from the 4th output onward.
- Same stream, mode=1 -> dout 2,7,15,25,35.
- W=8, DEPTH_LOG2=2: push 255 eight times -> dout saturates at 1020 (10 bits, no wrap); mean mode gives 255.
- Push 10,20, idle 3 cycles (in_valid=0), push 30 -> out_valid low during the gap, dout holds 30, then 60.
- After filling with 40s (sum 160), assert clear with in_valid=1 and din=99 -> 99 dropped, full=0; next push 5 -> dout 5.
- Mid-stream reset=0 for one cycle -> dout=0, out_valid=0, full=0; subsequent pushes 1,2,3,4 -> 1,3,6,10.
